mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Data-memory (MEM) stage of the single-clock MIPS datapath.
- A 1024 x 32-bit word-addressed RAM, addressed by the ALU result. It is written by store instructions and read by load instructions.
- Sits between the ALU/EX stage and the write-back mux. MEM_DataOut feeds the register-file write-data path.

Parameters:
- ADDR_WIDTH, 10, word-address width; depth = 2**ADDR_WIDTH words (1024).
- DATA_WIDTH, 32, word width in bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- MEM_WrEn  input  1  write enable; 1 = store the current word at the rising edge.
- ALU_MEM_Addr  input  ADDR_WIDTH  word address from the ALU (word index, not a byte address).
- MEM_DataIn  input  DATA_WIDTH  store data, from register-file read port B.
- MEM_DataOut  output  DATA_WIDTH  registered load data.

Behaviour:
- Single clock domain; one synchronous, active-high reset. No asynchronous paths except the output register's Q.
- Reset (rst=1 at a rising edge):
  - MEM_DataOut <= 0.
  - All 1024 words cleared to 0 in that same edge.
  - rst has priority over MEM_WrEn; no write occurs in a reset cycle.
- Write (rst=0, MEM_WrEn=1 at a rising edge): mem[ALU_MEM_Addr] <= MEM_DataIn. The full 32-bit word is written; there are no byte enables.
- Read:
  - Every rising edge with rst=0 updates MEM_DataOut <= mem[ALU_MEM_Addr].
  - Read latency is 1 clock; the output is held stable between edges.
- Read-during-write to the same address is read-first: MEM_DataOut receives the word's previous contents. The new data appears on the next edge that reads that address.
- Addressing: the full ADDR_WIDTH range is valid, 0..1023; there is no out-of-range condition.
  - Address 0 and address 1 are distinct 32-bit words.
  - There is no byte-offset shifting inside the block; callers pass a word index.
- Power-up contents before the first reset are undefined (X in simulation). Verification must reset first or write before reading.
- Reset asserted mid-sequence: takes effect at the next rising edge; prior writes are lost.
- MEM_WrEn, ALU_MEM_Addr and MEM_DataIn are sampled only at the rising edge. Glitches between edges have no effect.
- The memory is inferable as a synchronous single-port RAM, with an explicit clear loop for reset.

Test Plan:
- Reset then read: rst=1 for one edge; then rst=0, WrEn=0, addr=0, then addr=1023 -> MEM_DataOut = 0 after each edge.
- Basic write/read:
  - WrEn=1, addr=0, din=5 at edge 1.
  - WrEn=1, addr=1, din=666 at edge 2.
  - WrEn=0, addr=0 at edge 3 -> MEM_DataOut=5 after edge 3.
  - Then addr=1 -> MEM_DataOut=666 after the next edge.
- Read-first collision:
  - mem[4]=0x11111111; then WrEn=1, addr=4, din=0x22222222 -> MEM_DataOut=0x11111111 after that edge.
  - Then WrEn=0, addr=4 -> 0x22222222.
- Write-enable gating: WrEn=0, addr=7, din=0xDEADBEEF; then read addr 7 -> MEM_DataOut=0 (the write must not occur).
- Address extremes and independence:
  - Write 0xAAAAAAAA to addr 0 and 0x55555555 to addr 1023.
  - Read both -> each holds its own value, with no aliasing.
- Reset clears: after the writes above, pulse rst=1 with WrEn=1, addr=0, din=9 -> MEM_DataOut=0. Subsequent reads of 0, 1, 1023 return 0 (reset beats write).

Source files
------------

// File: rtl/mem_stage.sv
// Data-memory stage: word-addressed synchronous RAM with a registered read
// port, read-first on same-address collisions and a single-edge full clear.
module mem_stage #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MEM_WrEn,
  input  logic [ADDR_WIDTH-1:0] ALU_MEM_Addr,
  input  logic [DATA_WIDTH-1:0] MEM_DataIn,
  output logic [DATA_WIDTH-1:0] MEM_DataOut
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // One storage word per address; reset clears every word on the same edge
  // and takes priority over a pending store.
  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    always_ff @(posedge clk) begin
      if (rst) begin
        mem[g] <= '0;
      end else if (MEM_WrEn && (ALU_MEM_Addr == ADDR_WIDTH'(g))) begin
        mem[g] <= MEM_DataIn;
      end
    end
  end

  // Registered load data; sees the pre-write contents, giving read-first.
  always_ff @(posedge clk) begin
    if (rst) begin
      MEM_DataOut <= '0;
    end else begin
      MEM_DataOut <= mem[ALU_MEM_Addr];
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed stimulus pushes hand-computed
// expected load data per edge; an independent monitor pops and compares.
module tb_mem_stage;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst;
  logic          MEM_WrEn;
  logic [AW-1:0] ALU_MEM_Addr;
  logic [DW-1:0] MEM_DataIn;
  logic [DW-1:0] MEM_DataOut;

  typedef struct {
    logic [DW-1:0] val;
    string         name;
  } exp_t;

  exp_t exp_q[$];
  int   errors;
  int   checks;

  mem_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .MEM_WrEn     (MEM_WrEn),
    .ALU_MEM_Addr (ALU_MEM_Addr),
    .MEM_DataIn   (MEM_DataIn),
    .MEM_DataOut  (MEM_DataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs at the falling edge and record what the next
  // rising edge must produce.
  task automatic step(input logic r, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [DW-1:0] e,
                      input string nm);
    exp_t x;
    @(negedge clk);
    rst          = r;
    MEM_WrEn     = we;
    ALU_MEM_Addr = a;
    MEM_DataIn   = d;
    x.val  = e;
    x.name = nm;
    exp_q.push_back(x);
  endtask

  // Pulse write enable between edges only; it must be ignored.
  task automatic glitch_step(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [DW-1:0] e, input string nm);
    exp_t x;
    @(negedge clk);
    rst          = 1'b0;
    ALU_MEM_Addr = a;
    MEM_DataIn   = d;
    MEM_WrEn     = 1'b1;
    #2;
    MEM_WrEn     = 1'b0;
    x.val  = e;
    x.name = nm;
    exp_q.push_back(x);
  endtask

  // Monitor: every rising edge presents new load data; compare just after the
  // edge and again later in the high phase to confirm it is held.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        checks++;
        if (MEM_DataOut !== x.val) begin
          errors++;
          $display("FAIL %s: got %h expected %h", x.name, MEM_DataOut, x.val);
        end
        #3;
        checks++;
        if (MEM_DataOut !== x.val) begin
          errors++;
          $display("FAIL %s_hold: got %h expected %h", x.name, MEM_DataOut, x.val);
        end
      end
    end
  end

  initial begin
    int wait_cycles;
    errors       = 0;
    checks       = 0;
    rst          = 1'b1;
    MEM_WrEn     = 1'b0;
    ALU_MEM_Addr = '0;
    MEM_DataIn   = '0;

    // Reset then read both ends
    step(1'b1, 1'b0, 10'd0,    32'h0, 32'h0, "reset_out");
    step(1'b0, 1'b0, 10'd0,    32'h0, 32'h0, "rst_rd0");
    step(1'b0, 1'b0, 10'd1023, 32'h0, 32'h0, "rst_rd1023");

    // Basic write/read (write cycles read-first the old zero)
    step(1'b0, 1'b1, 10'd0, 32'd5,   32'h0,   "wr0_rf");
    step(1'b0, 1'b1, 10'd1, 32'd666, 32'h0,   "wr1_rf");
    step(1'b0, 1'b0, 10'd0, 32'h0,   32'd5,   "rd0_5");
    step(1'b0, 1'b0, 10'd1, 32'h0,   32'd666, "rd1_666");

    // Read-first collision
    step(1'b0, 1'b1, 10'd4, 32'h11111111, 32'h0,        "wr4_a");
    step(1'b0, 1'b1, 10'd4, 32'h22222222, 32'h11111111, "collide_rf");
    step(1'b0, 1'b0, 10'd4, 32'h0,        32'h22222222, "rd4_new");

    // Write-enable gating, including a between-edge glitch
    step(1'b0, 1'b0, 10'd7, 32'hDEADBEEF, 32'h0, "nowr7");
    step(1'b0, 1'b0, 10'd7, 32'h0,        32'h0, "rd7_zero");
    glitch_step(10'd9, 32'hCAFEF00D, 32'h0, "glitch9");
    step(1'b0, 1'b0, 10'd9, 32'h0,        32'h0, "rd9_zero");

    // Address extremes and independence
    step(1'b0, 1'b1, 10'd0,    32'hAAAAAAAA, 32'd5,        "wr0_ext");
    step(1'b0, 1'b1, 10'd1023, 32'h55555555, 32'h0,        "wr1023");
    step(1'b0, 1'b0, 10'd0,    32'h0,        32'hAAAAAAAA, "rd0_ext");
    step(1'b0, 1'b0, 10'd1023, 32'h0,        32'h55555555, "rd1023_ext");
    step(1'b0, 1'b0, 10'd1,    32'h0,        32'd666,      "rd1_keep");

    // Reset beats write and clears everything
    step(1'b1, 1'b1, 10'd0,    32'd9, 32'h0, "rst_wr");
    step(1'b0, 1'b0, 10'd0,    32'h0, 32'h0, "clr0");
    step(1'b0, 1'b0, 10'd1,    32'h0, 32'h0, "clr1");
    step(1'b0, 1'b0, 10'd1023, 32'h0, 32'h0, "clr1023");
    step(1'b0, 1'b0, 10'd4,    32'h0, 32'h0, "clr4");

    // Drain the scoreboard with a bounded wait
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
